mem_bus_arbiter: RTL and testbench

//  Shares the single data-side slave bus (memory map -> RAM/UART) between two requesters:

---
 rtl/mem_bus_arbiter_pkg.sv | 14 +
 rtl/mem_bus_arbiter_if.sv | 31 +++
 rtl/mem_bus_arbiter_cnt.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 97 +++++++++
 tb/tb_mem_bus_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_arb_pkg: shared types for mem_bus_arbiter
//   owner_e    bus ownership register encoding (parks on OWN_CPU)
//   mem_req_t  one requester's request fields, same layout for CPU and DMA
package mem_arb_pkg;
    localparam int AW = 32;
    localparam int DW = 32;
    typedef enum logic {OWN_CPU, OWN_DMA} owner_e;
    typedef struct packed {
        logic          req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: CPU port, DMA port and memory-map bus of the data-side arbiter
//   slave  modport: arbiter view (takes requests and bus_rd, drives acks, rdata, stall, bus strobes)
//   master modport: environment view (requesters plus memory map)
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = AW,
    parameter int DATA_WIDTH = DW
);
    logic                  cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata, cpu_rdata;
    logic                  dma_req, dma_we, dma_lock, dma_ack;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata, dma_rdata;
    logic                  bus_we, bus_re;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wd, bus_rd;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock, bus_rd,
        output cpu_ack, cpu_rdata, cpu_stall, dma_ack, dma_rdata,
        output bus_we, bus_re, bus_addr, bus_wd
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock, bus_rd,
        input  cpu_ack, cpu_rdata, cpu_stall, dma_ack, dma_rdata,
        input  bus_we, bus_re, bus_addr, bus_wd
    );
endinterface

// File: rtl/mem_bus_arbiter_cnt.sv
// arb_sat_counter: saturating up-counter with synchronous clear
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clr       clear to 0 (wins over i_inc)
//   i_inc       increment unless already at MAX
//   o_cnt       count value
//   o_sat       count has reached MAX
module arb_sat_counter #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_sat
);
    assign o_sat = o_cnt == MAX;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_cnt <= '0;
        else if (i_clr)
            o_cnt <= '0;
        else if (i_inc && !o_sat)
            o_cnt <= o_cnt + 1'b1;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the data-side memory bus between the CPU MEM stage and a debug/loader DMA
//   clk, rst_n    clock, asynchronous active-low reset
//   bif           mem_bus_arbiter_if.slave: CPU/DMA request ports, acks, rdata, cpu_stall, memory-map bus
//   perf_*        cpu grant / dma grant / cpu stall cycle counters
// Optional feature macro MEM_ARB_PERF_EN builds the saturating perf counters; without it perf_* read 0.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = AW,
    parameter int DATA_WIDTH   = DW,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_LOCK     = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_bus_arbiter_if.slave     bif,
    output logic [CNT_WIDTH-1:0] perf_cpu_gnt,
    output logic [CNT_WIDTH-1:0] perf_dma_gnt,
    output logic [CNT_WIDTH-1:0] perf_stall
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    // lock counter only needs to tell "fewer than MAX_LOCK-1 locked accesses", so it saturates there
    localparam int LW = $clog2(MAX_LOCK) + 1;

    owner_e        owner, owner_nxt;
    mem_req_t      cpu, dma, sel;
    logic          go, starve_sat, lock_sat, unused_ok;
    logic [SW-1:0] starve_cnt;
    logic [LW-1:0] lock_cnt;
    logic [2:0]    perf_sat;

    assign cpu = '{req: bif.cpu_req, we: bif.cpu_we, addr: AW'(bif.cpu_addr), wdata: DW'(bif.cpu_wdata)};
    assign dma = '{req: bif.dma_req, we: bif.dma_we, addr: AW'(bif.dma_addr), wdata: DW'(bif.dma_wdata)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            owner <= OWN_CPU;
        else
            owner <= owner_nxt;
    end

    // rst_n gates every ack so a reset mid-access kills the bus strobes immediately
    always_comb begin
        owner_nxt     = owner;
        sel           = (owner == OWN_CPU) ? cpu : dma;
        go            = rst_n & sel.req;
        owner_nxt     = (owner == OWN_CPU)
                      ? ((bif.dma_req && (!bif.cpu_req || starve_sat)) ? OWN_DMA : OWN_CPU)
                      : ((!bif.dma_req || (bif.cpu_req && !(bif.dma_lock && !lock_sat))) ? OWN_CPU : OWN_DMA);
        bif.cpu_ack   = go && owner == OWN_CPU;
        bif.dma_ack   = go && owner == OWN_DMA;
        bif.cpu_stall = bif.cpu_req & ~bif.cpu_ack;
        bif.bus_we    = go & sel.we;
        bif.bus_re    = go & ~sel.we;
        bif.bus_addr  = go ? ADDR_WIDTH'(sel.addr) : '0;
        bif.bus_wd    = go ? DATA_WIDTH'(sel.wdata) : '0;
        bif.cpu_rdata = bif.cpu_ack ? bif.bus_rd : '0;
        bif.dma_rdata = bif.dma_ack ? bif.bus_rd : '0;
    end

    arb_sat_counter #(.WIDTH(SW), .MAX(SW'(STARVE_LIMIT))) u_starve (
        .clk(clk), .rst_n(rst_n),
        .i_clr(owner == OWN_CPU && owner_nxt == OWN_DMA),
        .i_inc(bif.cpu_ack & bif.dma_req),
        .o_cnt(starve_cnt), .o_sat(starve_sat)
    );

    arb_sat_counter #(.WIDTH(LW), .MAX(LW'(MAX_LOCK - 1))) u_lock (
        .clk(clk), .rst_n(rst_n),
        .i_clr(owner == OWN_DMA && owner_nxt == OWN_CPU),
        .i_inc(bif.dma_ack & bif.dma_lock & bif.cpu_req),
        .o_cnt(lock_cnt), .o_sat(lock_sat)
    );

`ifdef MEM_ARB_PERF_EN
    arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_perf_cpu (
        .clk(clk), .rst_n(rst_n), .i_clr(1'b0), .i_inc(bif.cpu_ack),
        .o_cnt(perf_cpu_gnt), .o_sat(perf_sat[0])
    );
    arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_perf_dma (
        .clk(clk), .rst_n(rst_n), .i_clr(1'b0), .i_inc(bif.dma_ack),
        .o_cnt(perf_dma_gnt), .o_sat(perf_sat[1])
    );
    arb_sat_counter #(.WIDTH(CNT_WIDTH)) u_perf_stall (
        .clk(clk), .rst_n(rst_n), .i_clr(1'b0), .i_inc(bif.cpu_stall),
        .o_cnt(perf_stall), .o_sat(perf_sat[2])
    );
`else
    assign perf_cpu_gnt = '0;
    assign perf_dma_gnt = '0;
    assign perf_stall   = '0;
    assign perf_sat     = '0;
`endif

    assign unused_ok = ^{starve_cnt, lock_cnt, perf_sat};
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic checked against a cycle reference model
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int SL = 4;
    localparam int ML = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   rd_val;
    logic [CW-1:0] p_c, p_d, p_s;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();
    assign bif.bus_rd = rd_val;

    mem_bus_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(SL), .MAX_LOCK(ML), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bif(bif),
        .perf_cpu_gnt(p_c), .perf_dma_gnt(p_d), .perf_stall(p_s)
    );

    int n_chk = 0;
    int n_bad = 0;

    // reference model: who owns the bus, how long DMA has waited, how many locked accesses so far
    bit m_dma;
    int m_starve, m_lock, pc_c, pc_d, pc_s;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m_clear();
        m_dma = 0; m_starve = 0; m_lock = 0;
        pc_c = 0; pc_d = 0; pc_s = 0;
    endtask

    task automatic drv(input bit cr, cw, input logic [31:0] ca, cd,
                       input bit dr, dw, input logic [31:0] da, dd, input bit dl);
        bif.cpu_req = cr; bif.cpu_we = cw; bif.cpu_addr = ca; bif.cpu_wdata = cd;
        bif.dma_req = dr; bif.dma_we = dw; bif.dma_addr = da; bif.dma_wdata = dd;
        bif.dma_lock = dl;
    endtask

    function automatic logic [47:0] perf_exp();
`ifdef MEM_ARB_PERF_EN
        return {CW'(pc_c), CW'(pc_d), CW'(pc_s)};
`else
        return 48'h0;
`endif
    endfunction

    // called just after a posedge with inputs applied; checks outputs, then advances the model over the next edge
    task automatic step(output bit ec, output bit ed);
        bit go, stay;
        logic [31:0] ea, ew;
        ec = bif.cpu_req & ~m_dma;
        ed = bif.dma_req & m_dma;
        ea = ec ? bif.cpu_addr : ed ? bif.dma_addr : 32'h0;
        ew = ec ? bif.cpu_wdata : ed ? bif.dma_wdata : 32'h0;
        #2;
        chk("acks", {bif.cpu_ack, bif.dma_ack, bif.cpu_stall, bif.bus_we, bif.bus_re},
            {ec, ed, bif.cpu_req & ~ec, (ec & bif.cpu_we) | (ed & bif.dma_we),
             (ec & ~bif.cpu_we) | (ed & ~bif.dma_we)});
        chk("bus_addr", bif.bus_addr, ea);
        chk("bus_wd", bif.bus_wd, ew);
        chk("cpu_rdata", bif.cpu_rdata, ec ? rd_val : 32'h0);
        chk("dma_rdata", bif.dma_rdata, ed ? rd_val : 32'h0);
        chk("perf", {p_c, p_d, p_s}, perf_exp());
        @(posedge clk);
        pc_c += int'(ec);
        pc_d += int'(ed);
        pc_s += int'(bif.cpu_req & ~ec);
        if (!m_dma) begin
            go = bif.dma_req && (!bif.cpu_req || m_starve == SL);
            if (go) m_starve = 0;
            else if (ec && bif.dma_req && m_starve < SL) m_starve++;
            m_dma = go;
        end else begin
            stay = bif.dma_req && !(bif.cpu_req && !(bif.dma_lock && m_lock < ML - 1));
            if (!stay) m_lock = 0;
            else if (ed && bif.dma_lock && bif.cpu_req) m_lock++;
            m_dma = stay;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit ec, ed;
        logic [11:0] seq;
        int dcnt, ccnt, scnt;
        m_clear();
        rd_val = 32'h0;
        drv(1, 1, 32'h1, 32'h2, 1, 1, 32'h3, 32'h4, 1);
        #1;
        chk("rst_state", {bif.cpu_ack, bif.dma_ack, bif.bus_we, bif.bus_re}, 4'b0);
        chk("rst_perf", {p_c, p_d, p_s}, 48'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: CPU write issues in the same cycle
        drv(1, 1, 32'h10010004, 32'hA5, 0, 0, 0, 0, 0);
        #1;
        chk("t1_ack", {bif.cpu_ack, bif.bus_we, bif.cpu_stall}, 3'b110);
        chk("t1_addr", bif.bus_addr, 32'h10010004);
        step(ec, ed);

        // 2: lone DMA read takes one switch cycle, then ownership returns to the CPU
        drv(0, 0, 0, 0, 1, 0, 32'h10010008, 0, 0);
        rd_val = 32'h55;
        #1;
        chk("t2_c0", bif.dma_ack, 1'b0);
        step(ec, ed);
        #1;
        chk("t2_c1", {bif.dma_ack, bif.dma_rdata}, {1'b1, 32'h55});
        step(ec, ed);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(ec, ed);
        drv(1, 0, 32'h10010010, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t2_back", bif.cpu_ack, 1'b1);
        step(ec, ed);

        // 3 and 6: both requesting, starvation forces one DMA access after 5 CPU accesses
        do_reset();
        drv(1, 0, 32'h10010040, 0, 1, 0, 32'h10010080, 0, 0);
        seq = '0;
        for (int i = 0; i < 12; i++) begin
            step(ec, ed);
            seq[i] = ec;
        end
        chk("t3_seq", seq, 12'h7DF);
        chk("t6_perf", {p_c, p_d, p_s},
`ifdef MEM_ARB_PERF_EN
            {16'd10, 16'd2, 16'd2}
`else
            48'h0
`endif
        );

        // 4: locked DMA burst holds the CPU off for exactly MAX_LOCK accesses
        drv(0, 0, 0, 0, 1, 1, 32'h10010100, 32'h1, 1);
        step(ec, ed);
        step(ec, ed);
        chk("t4_own", ed, 1'b1);
        drv(1, 0, 32'h10010200, 0, 1, 1, 32'h10010104, 32'h2, 1);
        dcnt = 0; ccnt = 0; scnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            scnt += int'(bif.cpu_stall);
            step(ec, ed);
            dcnt += int'(ed);
            ccnt += int'(ec);
        end
        chk("t4_dma_acks", dcnt, 8);
        chk("t4_cpu_acks", ccnt, 2);
        chk("t4_stalls", scnt, 8);

        // 5: asynchronous reset in the middle of a DMA burst
        drv(0, 0, 0, 0, 1, 0, 32'h10010020, 0, 1);
        step(ec, ed);
        step(ec, ed);
        drv(1, 0, 32'h10010030, 0, 1, 1, 32'h10010024, 32'hDEAD, 1);
        #1;
        chk("t5_pre", {bif.dma_ack, bif.bus_we}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("t5_rst", {bif.cpu_ack, bif.dma_ack, bif.bus_we, bif.bus_re}, 4'b0);
        m_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drv(1, 0, 32'h10010030, 0, 1, 1, 32'h10010024, 32'hDEAD, 1);
        #1;
        chk("t5_first", bif.cpu_ack, 1'b1);
        step(ec, ed);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 1)));
            rd_val = $urandom;
            step(ec, ed);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
